ram_1port_arb: RTL and testbench

RAM_1PORT_ARB -- requirements
Module: ram_1port_arb

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/ram_rsp_pipe.sv | 38 +++
 rtl/ram_1port_arb.sv | 139 +++++++++++++
 tb/tb_ram_1port_arb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the single-port RAM arbiter: requester ids,
// the read latencies of the two RAM output-register settings, and the
// {valid, id} tag carried down the response pipeline.
package ram_ctrl_pkg;

    // Requester identifiers
    localparam logic REQ_ID_A = 1'b0;
    localparam logic REQ_ID_B = 1'b1;

    // RAM read latency without / with the RAM output register
    localparam int RD_LATENCY_NO_OREG = 1;
    localparam int RD_LATENCY_OREG    = 2;

    // One entry of the response tracking delay line
    typedef struct packed {
        logic valid;
        logic id;
    } rsp_tag_t;

endpackage

// File: rtl/ram_rsp_pipe.sv
// Delay line for read-response tags. A tag entering on in_tag appears on
// out_tag exactly DEPTH clocks later, lining up with the RAM read data.
// Reset clears every stage so in-flight reads are dropped.
module ram_rsp_pipe
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH = RD_LATENCY_NO_OREG
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_tag_t in_tag,
    output rsp_tag_t out_tag
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        rsp_tag_t prev;
        rsp_tag_t tag_reg;

        // First stage takes the new tag, later stages take the stage before
        if (gi == 0) begin : g_first
            assign prev = in_tag;
        end else begin : g_rest
            assign prev = g_stage[gi-1].tag_reg;
        end

        // Stage register, cleared on reset to discard pending reads
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_reg <= '0;
            end else begin
                tag_reg <= prev;
            end
        end
    end

    assign out_tag = g_stage[DEPTH-1].tag_reg;

endmodule

// File: rtl/ram_1port_arb.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// At most one request is granted per cycle; the granted request drives the
// RAM directly in that cycle. Read responses are routed back to the issuing
// requester RD_LATENCY clocks later using a {valid, id} delay line.
module ram_1port_arb
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = RD_LATENCY_NO_OREG
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid_a,
    input  logic                  req_valid_b,
    output logic                  req_ready_a,
    output logic                  req_ready_b,
    input  logic                  req_we_a,
    input  logic                  req_we_b,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    input  logic [DATA_WIDTH-1:0] req_wdata_a,
    input  logic [DATA_WIDTH-1:0] req_wdata_b,

    output logic                  rsp_valid_a,
    output logic                  rsp_valid_b,
    output logic [DATA_WIDTH-1:0] rsp_data_a,
    output logic [DATA_WIDTH-1:0] rsp_data_b,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    // Requester that wins the next contended cycle
    logic     rr_ptr_reg;
    logic     rr_ptr_next;

    logic     grant_a;
    logic     grant_b;
    logic     handshake;
    logic     grant_id;
    logic     grant_we;

    rsp_tag_t pipe_in;
    rsp_tag_t pipe_out;

    // Grant selection: contention resolved by the pointer, lone request wins
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (req_valid_a && req_valid_b) begin
                if (rr_ptr_reg == REQ_ID_A) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (req_valid_a) begin
                grant_a = 1'b1;
            end else if (req_valid_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign handshake   = grant_a | grant_b;
    assign grant_id    = grant_b ? REQ_ID_B : REQ_ID_A;
    assign req_ready_a = grant_a;
    assign req_ready_b = grant_b;

    // RAM port mux: granted request in a handshake cycle, zeros otherwise
    always_comb begin
        ram_addr    = '0;
        ram_wr_data = '0;
        grant_we    = 1'b0;
        if (grant_a) begin
            ram_addr    = req_addr_a;
            ram_wr_data = req_wdata_a;
            grant_we    = req_we_a;
        end else if (grant_b) begin
            ram_addr    = req_addr_b;
            ram_wr_data = req_wdata_b;
            grant_we    = req_we_b;
        end
    end

    assign ram_wr_en = grant_we;

    // Pointer moves to the other requester only when a handshake happens
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (handshake) begin
            rr_ptr_next = (grant_id == REQ_ID_A) ? REQ_ID_B : REQ_ID_A;
        end
    end

    // Pointer register; reset favours requester A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= REQ_ID_A;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Only read handshakes enter the response pipeline
    assign pipe_in.valid = handshake && !grant_we;
    assign pipe_in.id    = grant_id;

    ram_rsp_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_tag  (pipe_in),
        .out_tag (pipe_out)
    );

    // Steer returning read data to its requester; zero data when not valid
    always_comb begin
        rsp_valid_a = 1'b0;
        rsp_valid_b = 1'b0;
        rsp_data_a  = '0;
        rsp_data_b  = '0;
        if (!rst && pipe_out.valid) begin
            if (pipe_out.id == REQ_ID_A) begin
                rsp_valid_a = 1'b1;
                rsp_data_a  = ram_rd_data;
            end else begin
                rsp_valid_b = 1'b1;
                rsp_data_b  = ram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_1port_arb.sv
// Directed bench for ram_1port_arb. Two instances share all request inputs:
// dut1 with read latency 1 and dut2 with read latency 2, each wired to its
// own behavioural RAM whose read path matches that latency.
module tb_ram_1port_arb;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic          req_we_a = 1'b0, req_we_b = 1'b0;
    logic [AW-1:0] req_addr_a = '0, req_addr_b = '0;
    logic [DW-1:0] req_wdata_a = '0, req_wdata_b = '0;

    logic          ready_a1, ready_b1, rv_a1, rv_b1, wen1;
    logic [DW-1:0] rd_a1, rd_b1, wdat1, ram_q1;
    logic [AW-1:0] addr1;

    logic          ready_a2, ready_b2, rv_a2, rv_b2, wen2;
    logic [DW-1:0] rd_a2, rd_b2, wdat2, ram_q2;
    logic [AW-1:0] addr2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_1port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
        .req_ready_a(ready_a1), .req_ready_b(ready_b1),
        .req_we_a(req_we_a), .req_we_b(req_we_b),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .req_wdata_a(req_wdata_a), .req_wdata_b(req_wdata_b),
        .rsp_valid_a(rv_a1), .rsp_valid_b(rv_b1),
        .rsp_data_a(rd_a1), .rsp_data_b(rd_b1),
        .ram_addr(addr1), .ram_wr_data(wdat1), .ram_wr_en(wen1),
        .ram_rd_data(ram_q1)
    );

    ram_1port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
        .req_ready_a(ready_a2), .req_ready_b(ready_b2),
        .req_we_a(req_we_a), .req_we_b(req_we_b),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .req_wdata_a(req_wdata_a), .req_wdata_b(req_wdata_b),
        .rsp_valid_a(rv_a2), .rsp_valid_b(rv_b2),
        .rsp_data_a(rd_a2), .rsp_data_b(rd_b2),
        .ram_addr(addr2), .ram_wr_data(wdat2), .ram_wr_en(wen2),
        .ram_rd_data(ram_q2)
    );

    // Behavioural RAMs: registered read, plus an output register for dut2
    logic [DW-1:0] mem1 [2**AW];
    logic [DW-1:0] mem2 [2**AW];
    logic [DW-1:0] q2_stage;

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (wen1) mem1[addr1] <= wdat1;
        ram_q1 <= mem1[addr1];
        if (wen2) mem2[addr2] <= wdat2;
        q2_stage <= mem2[addr2];
        ram_q2   <= q2_stage;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we_a = 1'b0; req_we_b = 1'b0;
        req_addr_a = '0; req_addr_b = '0;
        req_wdata_a = '0; req_wdata_b = '0;
    endtask

    initial begin
        // ---- Reset state: requests present but reset forces everything low
        req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 5'd3; req_wdata_a = 8'hAA;
        req_valid_b = 1'b1; req_addr_b = 5'd7;
        next_cycle();
        next_cycle();
        chk("rst_ready_a", 32'(ready_a1), 32'd0);
        chk("rst_ready_b", 32'(ready_b1), 32'd0);
        chk("rst_wr_en",   32'(wen1),     32'd0);
        chk("rst_addr",    32'(addr1),    32'd0);
        chk("rst_wdata",   32'(wdat1),    32'd0);
        chk("rst_rsp_a",   32'(rv_a1),    32'd0);
        chk("rst_rsp_b",   32'(rv_b1),    32'd0);
        chk("rst_data_a",  32'(rd_a1),    32'd0);
        idle();
        rst = 1'b0;

        // ---- A writes 0..31 with 0xFF..0xE0, B idle
        for (int i = 0; i < 32; i++) begin
            next_cycle();
            req_valid_a = 1'b1; req_we_a = 1'b1;
            req_addr_a  = AW'(i); req_wdata_a = DW'(255 - i);
            #1;
            chk($sformatf("wr%0d_ready_a", i), 32'(ready_a1), 32'd1);
            chk($sformatf("wr%0d_ready_b", i), 32'(ready_b1), 32'd0);
            chk($sformatf("wr%0d_wr_en", i),   32'(wen1),     32'd1);
            chk($sformatf("wr%0d_addr", i),    32'(addr1),    32'(i));
            chk($sformatf("wr%0d_wdata", i),   32'(wdat1),    32'(255 - i));
            chk($sformatf("wr%0d_rsp", i),     32'({rv_a1, rv_b1}), 32'd0);
        end

        // ---- No handshake: RAM port driven to zero, still no response
        next_cycle();
        idle();
        #1;
        chk("idle_wr_en", 32'(wen1),  32'd0);
        chk("idle_addr",  32'(addr1), 32'd0);
        chk("idle_wdata", 32'(wdat1), 32'd0);
        chk("idle_rsp",   32'({rv_a1, rv_b1, rv_a2, rv_b2}), 32'd0);

        // ---- B writes 0x5A to addr 10 then reads it back next cycle
        next_cycle();
        req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 5'd10; req_wdata_b = 8'h5A;
        #1;
        chk("bwr_ready_b", 32'(ready_b1), 32'd1);
        chk("bwr_wr_en",   32'(wen1),     32'd1);
        chk("bwr_wdata",   32'(wdat1),    32'h5A);
        next_cycle();
        req_we_b = 1'b0; req_wdata_b = '0;
        #1;
        chk("brd_ready_b", 32'(ready_b1), 32'd1);
        chk("brd_wr_en",   32'(wen1),     32'd0);
        chk("brd_addr",    32'(addr1),    32'd10);
        next_cycle();
        idle();
        #1;
        chk("brd_rsp_b",   32'(rv_b1), 32'd1);
        chk("brd_data_b",  32'(rd_b1), 32'h5A);
        chk("brd_rsp_a",   32'(rv_a1), 32'd0);
        chk("brd_l2_early", 32'(rv_b2), 32'd0);
        next_cycle();
        chk("brd_l2_rsp_b",  32'(rv_b2), 32'd1);
        chk("brd_l2_data_b", 32'(rd_b2), 32'h5A);

        // ---- Contended reads: A addr 3 (0xFC), B addr 7 (0xF8); last winner was B
        for (int k = 0; k < 7; k++) begin
            if (k > 0) next_cycle();
            if (k < 6) begin
                req_valid_a = 1'b1; req_addr_a = 5'd3;
                req_valid_b = 1'b1; req_addr_b = 5'd7;
            end else begin
                idle();
            end
            #1;
            if (k < 6) begin
                chk($sformatf("rr%0d_ready_a", k), 32'(ready_a1), 32'((k % 2) == 0));
                chk($sformatf("rr%0d_ready_b", k), 32'(ready_b1), 32'((k % 2) == 1));
                chk($sformatf("rr%0d_addr", k),    32'(addr1),    (k % 2 == 0) ? 32'd3 : 32'd7);
            end
            chk($sformatf("rr%0d_rsp_a", k),  32'(rv_a1), 32'(k >= 1 && ((k - 1) % 2) == 0));
            chk($sformatf("rr%0d_data_a", k), 32'(rd_a1), (k >= 1 && ((k - 1) % 2) == 0) ? 32'hFC : 32'd0);
            chk($sformatf("rr%0d_rsp_b", k),  32'(rv_b1), 32'(k >= 1 && ((k - 1) % 2) == 1));
            chk($sformatf("rr%0d_data_b", k), 32'(rd_b1), (k >= 1 && ((k - 1) % 2) == 1) ? 32'hF8 : 32'd0);
        end

        // ---- A reads 0,1,2 back-to-back; latency 1 and latency 2 responses
        for (int j = 0; j < 5; j++) begin
            next_cycle();
            if (j < 3) begin
                idle();
                req_valid_a = 1'b1; req_addr_a = AW'(j);
            end else begin
                idle();
            end
            #1;
            chk($sformatf("l1_%0d_rsp_a", j),  32'(rv_a1), 32'(j >= 1 && j <= 3));
            chk($sformatf("l1_%0d_data_a", j), 32'(rd_a1), (j >= 1 && j <= 3) ? 32'(256 - j) : 32'd0);
            chk($sformatf("l2_%0d_rsp_a", j),  32'(rv_a2), 32'(j >= 2));
            chk($sformatf("l2_%0d_data_a", j), 32'(rd_a2), (j >= 2) ? 32'(257 - j) : 32'd0);
        end

        // ---- Reset in the cycle after A's read grant
        next_cycle();
        req_valid_a = 1'b1; req_addr_a = 5'd5;
        #1;
        chk("mr_grant_a", 32'(ready_a1), 32'd1);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("mr_in_rst_rsp_a", 32'({rv_a1, rv_a2}), 32'd0);
        chk("mr_in_rst_ready", 32'(ready_a1), 32'd0);
        next_cycle();
        idle();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            chk($sformatf("mr_post%0d_rsp", j), 32'({rv_a1, rv_b1, rv_a2, rv_b2}), 32'd0);
        end
        req_valid_a = 1'b1; req_addr_a = 5'd3;
        req_valid_b = 1'b1; req_addr_b = 5'd7;
        #1;
        chk("mr_first_ready_a", 32'(ready_a1), 32'd1);
        chk("mr_first_ready_b", 32'(ready_b1), 32'd0);
        next_cycle();
        idle();
        #1;
        chk("mr_first_rsp_a",  32'(rv_a1), 32'd1);
        chk("mr_first_data_a", 32'(rd_a1), 32'hFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
